// File: rtl/nn_mlp_sequencer_pkg.sv
// Shared sizes, FSM encoding and arithmetic helpers for the MLP sequencer.
// No logic state; pure constants and combinational functions.
// Parameter RAM layout is row-major: W1, B1, W2, B2.
package nn_mlp_sequencer_pkg;

    localparam int IN_SIZE  = 4;
    localparam int HIDDEN1  = 3;
    localparam int OUT_SIZE = 2;
    localparam int WIDTH    = 16;
    localparam int FRAC     = 8;
    localparam int ACC_W    = 40;

    localparam int DEPTH  = HIDDEN1*IN_SIZE + HIDDEN1 + OUT_SIZE*HIDDEN1 + OUT_SIZE;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CLS_W  = $clog2(OUT_SIZE);

    // Step counter covers fan-in reads, the bias read and the write cycle.
    localparam int MAX_FAN = (IN_SIZE > HIDDEN1) ? IN_SIZE : HIDDEN1;
    localparam int MAX_NRN = (HIDDEN1 > OUT_SIZE) ? HIDDEN1 : OUT_SIZE;
    localparam int STEP_W  = $clog2(MAX_FAN + 2);
    localparam int NRN_W   = $clog2(MAX_NRN + 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2**(WIDTH-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2**(WIDTH-1)));

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_L1,
        ST_L2,
        ST_OUT
    } state_t;

    function automatic int w1_base();
        return 0;
    endfunction

    function automatic int b1_base();
        return HIDDEN1*IN_SIZE;
    endfunction

    function automatic int w2_base();
        return b1_base() + HIDDEN1;
    endfunction

    function automatic int b2_base();
        return w2_base() + OUT_SIZE*HIDDEN1;
    endfunction

    // Drop the fractional bits (floor) and clamp into the data range.
    function automatic logic signed [WIDTH-1:0] sat_shift(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] sh;
        logic signed [WIDTH-1:0] r;
        sh = acc >>> FRAC;
        if (sh > SAT_MAX) begin
            r = SAT_MAX[WIDTH-1:0];
        end else if (sh < SAT_MIN) begin
            r = SAT_MIN[WIDTH-1:0];
        end else begin
            r = sh[WIDTH-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/nn_mlp_sequencer_if.sv
// Bundles the feature stream, parameter RAM port and result handshake.
// slave = the sequencer; master = its environment (source, RAM, sink).
// Backpressure via in_ready/out_ready; RAM read data returns one cycle after mem_rd_en.
interface nn_mlp_sequencer_if;
    import nn_mlp_sequencer_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        in_data;
    logic                    mem_rd_en;
    logic [ADDR_W-1:0]       mem_addr;
    logic [WIDTH-1:0]        mem_rdata;
    logic                    out_valid;
    logic                    out_ready;
    logic [CLS_W-1:0]        out_class;
    logic [WIDTH-1:0]        out_logit;
    logic                    busy;

    modport slave (
        input  in_valid, in_data, mem_rdata, out_ready,
        output in_ready, mem_rd_en, mem_addr, out_valid, out_class, out_logit, busy
    );

    modport master (
        output in_valid, in_data, mem_rdata, out_ready,
        input  in_ready, mem_rd_en, mem_addr, out_valid, out_class, out_logit, busy
    );

endinterface

// File: rtl/nn_mlp_sequencer_mac.sv
// Shared multiply-accumulate: clear, accumulate weight*x, finalize with bias.
// Accumulator updates one cycle after acc_en; result is combinational from acc and bias.
// No backpressure; the sequencer drives the controls every cycle.
module nn_mlp_sequencer_mac
    import nn_mlp_sequencer_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    acc_en,
    input  logic signed [WIDTH-1:0] weight,
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] bias,
    output logic signed [WIDTH-1:0] result
);
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext, bias_ext;

    // Next accumulator value and the bias-adjusted, saturated neuron output.
    always_comb begin
        prod     = (2*WIDTH)'(weight) * (2*WIDTH)'(x);
        prod_ext = ACC_W'(prod);
        bias_ext = ACC_W'(bias) <<< FRAC;
        acc_d    = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (acc_en) begin
            acc_d = acc_q + prod_ext;
        end
        result = sat_shift(acc_q + bias_ext);
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/nn_mlp_sequencer.sv
// Time-multiplexed 2-layer MLP: streams features in, runs both layers on one MAC, emits argmax.
// Latency: out_valid rises HIDDEN1*(IN_SIZE+2)+OUT_SIZE*(HIDDEN1+2)+1 cycles after the last feature handshake.
// in_ready only in IDLE/LOAD; the result is held in OUT until out_ready, no new sample until then.
module nn_mlp_sequencer
    import nn_mlp_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    nn_mlp_sequencer_if.slave bus
);
    state_t                  state_q, state_d;
    logic [STEP_W-1:0]       k_q, k_d, fan, x_idx;
    logic [NRN_W-1:0]        n_q, n_d, last_nrn;
    logic signed [WIDTH-1:0] feat_q [IN_SIZE];
    logic signed [WIDTH-1:0] feat_d [IN_SIZE];
    logic signed [WIDTH-1:0] hid_q  [HIDDEN1];
    logic signed [WIDTH-1:0] hid_d  [HIDDEN1];
    logic signed [WIDTH-1:0] best_logit_q, best_logit_d;
    logic [CLS_W-1:0]        best_cls_q, best_cls_d;
    logic                    out_valid_q, out_valid_d;
    logic                    in_ready_q, in_ready_d;
    logic                    in_hs, out_hs, mac_clr, mac_acc, rd_en;
    logic signed [WIDTH-1:0] x_op, mac_res, rdata;
    int                      addr_int, w_base, b_base;

    assign rdata = $signed(bus.mem_rdata);

    nn_mlp_sequencer_mac u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (mac_clr),
        .acc_en (mac_acc),
        .weight (rdata),
        .x      (x_op),
        .bias   (rdata),
        .result (mac_res)
    );

    // Next-state, counters, RAM addressing, buffer writes and running argmax.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        n_d          = n_q;
        feat_d       = feat_q;
        hid_d        = hid_q;
        best_logit_d = best_logit_q;
        best_cls_d   = best_cls_q;
        out_valid_d  = 1'b0;
        rd_en        = 1'b0;
        addr_int     = 0;
        mac_clr      = 1'b0;
        mac_acc      = 1'b0;
        x_op         = '0;

        fan      = (state_q == ST_L1) ? STEP_W'(IN_SIZE) : STEP_W'(HIDDEN1);
        last_nrn = (state_q == ST_L1) ? NRN_W'(HIDDEN1 - 1) : NRN_W'(OUT_SIZE - 1);
        w_base   = (state_q == ST_L1) ? w1_base() : w2_base();
        b_base   = (state_q == ST_L1) ? b1_base() : b2_base();
        x_idx    = k_q - STEP_W'(1);
        in_hs    = in_ready_q & bus.in_valid;
        out_hs   = out_valid_q & bus.out_ready;

        // Step k consumes the weight read at step k-1, so it pairs with input k-1.
        for (int j = 0; j < IN_SIZE; j++) begin
            if (state_q == ST_L1 && x_idx == STEP_W'(j)) x_op = feat_q[j];
        end
        for (int j = 0; j < HIDDEN1; j++) begin
            if (state_q == ST_L2 && x_idx == STEP_W'(j)) x_op = hid_q[j];
        end

        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (in_hs) begin
                    for (int j = 0; j < IN_SIZE; j++) begin
                        if (k_q == STEP_W'(j)) feat_d[j] = $signed(bus.in_data);
                    end
                    if (k_q == STEP_W'(IN_SIZE - 1)) begin
                        state_d = ST_L1;
                        k_d     = '0;
                        n_d     = '0;
                    end else begin
                        state_d = ST_LOAD;
                        k_d     = k_q + STEP_W'(1);
                    end
                end
            end
            ST_L1, ST_L2: begin
                mac_clr = (k_q == '0);
                mac_acc = (k_q != '0) && (k_q <= fan);
                if (k_q <= fan) begin
                    rd_en = 1'b1;
                    if (k_q < fan) addr_int = w_base + int'(n_q) * int'(fan) + int'(k_q);
                    else           addr_int = b_base + int'(n_q);
                end
                if (k_q == fan + STEP_W'(1)) begin
                    k_d = '0;
                    if (state_q == ST_L1) begin
                        for (int j = 0; j < HIDDEN1; j++) begin
                            if (n_q == NRN_W'(j)) hid_d[j] = mac_res[WIDTH-1] ? '0 : mac_res;
                        end
                    end else if (n_q == '0 || mac_res > best_logit_q) begin
                        best_logit_d = mac_res;
                        best_cls_d   = CLS_W'(n_q);
                    end
                    if (n_q == last_nrn) begin
                        n_d     = '0;
                        state_d = (state_q == ST_L1) ? ST_L2 : ST_OUT;
                    end else begin
                        n_d = n_q + NRN_W'(1);
                    end
                end else begin
                    k_d = k_q + STEP_W'(1);
                end
            end
            ST_OUT: begin
                out_valid_d = !out_hs;
                if (out_hs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    end

    // State, counters, buffers and output registers; reset aborts any sample in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            n_q          <= '0;
            best_logit_q <= '0;
            best_cls_q   <= '0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b0;
            for (int j = 0; j < IN_SIZE; j++) feat_q[j] <= '0;
            for (int j = 0; j < HIDDEN1; j++) hid_q[j]  <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            n_q          <= n_d;
            best_logit_q <= best_logit_d;
            best_cls_q   <= best_cls_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
            feat_q       <= feat_d;
            hid_q        <= hid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_rd_en = rd_en;
    assign bus.mem_addr  = ADDR_W'(addr_int);
    assign bus.out_valid = out_valid_q;
    assign bus.out_class = best_cls_q;
    assign bus.out_logit = best_logit_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nn_mlp_sequencer.sv
// Scoreboarded bench for nn_mlp_sequencer: directed cases plus randomized samples against an integer model.
// Expected results are queued when a sample's last feature is accepted; a negedge monitor pops and compares.
// Also checks output latency, stability under backpressure, and abort on reset.
module tb_nn_mlp_sequencer;

    localparam int NPAR = 23;
    localparam int LAT  = 29;

    typedef struct {
        int          cls;
        logic [15:0] logit;
        longint      hs_edge;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    exp_t        sb[$];
    logic [15:0] pmem [NPAR];
    logic [15:0] xv [4];
    int          checks = 0;
    int          errors = 0;
    longint      cyc = 0;
    int          exp_cls;
    logic [15:0] exp_logit;
    int          rdy_mode = 2;

    always #5 clk = ~clk;

    nn_mlp_sequencer_if bif();

    nn_mlp_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Parameter RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (bif.mem_rd_en) bif.mem_rdata <= (int'(bif.mem_addr) < NPAR) ? pmem[bif.mem_addr] : 16'hDEAD;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sink readiness changes just after posedge so it is stable when sampled.
    initial begin
        bif.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bif.out_ready = 1'($urandom_range(0, 1));
                1:       bif.out_ready = 1'b0;
                default: bif.out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: compare each delivered result, its latency, and hold behaviour.
    initial begin
        bit          prev_v = 0;
        bit          after = 0;
        longint      rise_cyc = 0;
        logic [15:0] held_logit = 0;
        int          held_cls = 0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 0;
                after  = 0;
            end else begin
                if (after) begin
                    chk("single_handshake", longint'(bif.out_valid), 0);
                    chk("in_ready_after_out", longint'(bif.in_ready), 1);
                    after = 0;
                end
                if (bif.out_valid) begin
                    chk("in_ready_in_out", longint'(bif.in_ready), 0);
                    if (!prev_v) begin
                        rise_cyc   = cyc;
                        held_cls   = int'(bif.out_class);
                        held_logit = bif.out_logit;
                    end else begin
                        chk("stable_class", longint'(bif.out_class), longint'(held_cls));
                        chk("stable_logit", longint'(bif.out_logit), longint'(held_logit));
                    end
                    if (bif.out_ready) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_output", 1, 0);
                        end else begin
                            e = sb.pop_front();
                            chk("out_class", longint'(bif.out_class), longint'(e.cls));
                            chk("out_logit", longint'(bif.out_logit), longint'(e.logit));
                            chk("latency", rise_cyc - e.hs_edge, LAT);
                        end
                        after  = 1;
                        prev_v = 0;
                    end else begin
                        prev_v = 1;
                    end
                end else begin
                    prev_v = 0;
                end
            end
        end
    end

    // Reference: plain integer arithmetic over the memory map.
    function automatic longint floor256(input longint a);
        return (a >= 0) ? a / 256 : -((-a + 255) / 256);
    endfunction

    function automatic longint sat16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model();
        longint hid [3];
        longint acc, v, best;
        for (int h = 0; h < 3; h++) begin
            acc = 0;
            for (int i = 0; i < 4; i++)
                acc += longint'($signed(pmem[h*4 + i])) * longint'($signed(xv[i]));
            acc += longint'($signed(pmem[12 + h])) * 256;
            v = sat16(floor256(acc));
            hid[h] = (v < 0) ? 0 : v;
        end
        best = 0;
        exp_cls = 0;
        for (int o = 0; o < 2; o++) begin
            acc = 0;
            for (int h = 0; h < 3; h++)
                acc += longint'($signed(pmem[15 + o*3 + h])) * hid[h];
            acc += longint'($signed(pmem[21 + o])) * 256;
            v = sat16(floor256(acc));
            if (o == 0 || v > best) begin
                best    = v;
                exp_cls = o;
            end
        end
        exp_logit = 16'(best);
    endtask

    task automatic send_sample();
        exp_t e;
        int   t;
        e.hs_edge = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rdy_mode == 0 && $urandom_range(0, 3) == 0) begin
                bif.in_valid = 1'b0;
                @(negedge clk);
            end
            bif.in_valid = 1'b1;
            bif.in_data  = xv[i];
            t = 0;
            while (!bif.in_ready && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (t >= 300) chk("in_ready_timeout", longint'(t), 0);
            e.hs_edge = cyc + 1;
        end
        @(negedge clk);
        bif.in_valid = 1'b0;
        e.cls   = exp_cls;
        e.logit = exp_logit;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((sb.size() != 0 || bif.busy) && t < 600) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", longint'(t < 600), 1);
    endtask

    task automatic check_zero(input string name);
        chk(name, longint'({bif.in_ready, bif.out_valid, bif.busy, bif.mem_rd_en,
                            bif.mem_addr, bif.out_class, bif.out_logit}), 0);
    endtask

    task automatic set_s1();
        for (int a = 0; a < 12; a++) pmem[a] = 16'h0100;
        for (int a = 12; a < 15; a++) pmem[a] = 16'h0000;
        for (int a = 15; a < 18; a++) pmem[a] = 16'h0080;
        for (int a = 18; a < 21; a++) pmem[a] = 16'hFF80;
        pmem[21] = 16'h0000;
        pmem[22] = 16'h0000;
        xv[0] = 16'h0100; xv[1] = 16'h0200; xv[2] = 16'h0300; xv[3] = 16'h0400;
    endtask

    task automatic rand_params(input bit wide);
        int r;
        for (int a = 0; a < NPAR; a++) begin
            r = wide ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 1024)) - 512;
            pmem[a] = 16'(r);
        end
    endtask

    task automatic rand_x(input bit wide);
        int r;
        for (int i = 0; i < 4; i++) begin
            r = wide ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 2048)) - 1024;
            xv[i] = 16'(r);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bif.in_valid = 1'b0;
        bif.in_data  = '0;

        #3 rst_n = 1'b0;
        #1 check_zero("reset_outputs");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: basic forward pass
        set_s1();
        exp_cls = 0; exp_logit = 16'h0F00;
        send_sample();
        wait_drain();

        // 2: negative hidden pre-activations clamp to zero; bias alone decides
        for (int a = 12; a < 15; a++) pmem[a] = 16'hEC00;
        pmem[21] = 16'h0000; pmem[22] = 16'h0040;
        exp_cls = 1; exp_logit = 16'h0040;
        send_sample();
        wait_drain();

        // 3: tie resolves to the lowest index
        pmem[21] = 16'h0040; pmem[22] = 16'h0040;
        exp_cls = 0; exp_logit = 16'h0040;
        send_sample();
        wait_drain();

        // 4: positive saturation in both layers
        set_s1();
        for (int a = 15; a < 18; a++) pmem[a] = 16'h0100;
        for (int a = 18; a < 21; a++) pmem[a] = 16'h0000;
        for (int i = 0; i < 4; i++) xv[i] = 16'h7F00;
        exp_cls = 0; exp_logit = 16'h7FFF;
        send_sample();
        wait_drain();

        // 5: held result under backpressure, then a back-to-back sample
        set_s1();
        rdy_mode = 1;
        exp_cls = 0; exp_logit = 16'h0F00;
        send_sample();
        xv[0] = 16'h0100; xv[1] = 16'h0100; xv[2] = 16'h0100; xv[3] = 16'hFF00;
        exp_cls = 0; exp_logit = 16'h0300;
        fork
            send_sample();
            begin
                t = 0;
                while (!bif.out_valid && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                chk("out_valid_timeout", longint'(t < 200), 1);
                repeat (10) @(negedge clk);
                rdy_mode = 2;
            end
        join
        wait_drain();

        // 6: reset during layer 1 aborts the sample, then a clean rerun
        set_s1();
        exp_cls = 0; exp_logit = 16'h0F00;
        send_sample();
        repeat (5) @(negedge clk);
        chk("busy_in_l1", longint'(bif.busy), 1);
        #2 rst_n = 1'b0;
        #1 check_zero("reset_mid_l1");
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("no_output_after_abort", longint'(bif.out_valid), 0);
        set_s1();
        exp_cls = 0; exp_logit = 16'h0F00;
        send_sample();
        wait_drain();

        // Randomized samples with random sink backpressure
        rdy_mode = 0;
        for (int j = 0; j < 24; j++) begin
            if (j % 6 == 0) begin
                wait_drain();
                rand_params(j % 12 == 6);
            end
            rand_x(j % 4 == 3);
            model();
            send_sample();
        end
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
